alu_result_checker: RTL and testbench

//  Self-checking sink on the result side of the 32-bit alu. Accepts one vector per handshake (operands, aluc, DUT r/flags),

---
 rtl/alu_result_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// -----------------------------------------------------------------------------
// alu_result_checker
//
// Self-checking sink for the result side of the 32-bit alu. Each accepted
// vector carries the operands, opcode and what the DUT produced (r and
// {zero,carry,negative,overflow}). The checker works out the golden result
// and flags, compares them, and keeps pass/fail counts plus a capture of the
// first failing vector. Intended for FPGA self-test.
//
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in RUN. A transfer can never be refused once it has
// been offered while in_ready is high; the checker never stalls.
//
// Pipeline:
//   S1 : registers inputs, golden r/flags and the per-field check mask.
//   S2 : compares the S1 contents and updates counters / first-failure capture
//        on the next edge. S2 has no separate payload: its registers are the
//        counters and the ff_* capture.
//
// FSM: IDLE -start-> RUN -stop-> DRAIN -S1 empty-> DONE -start-> RUN.
//   start clears counters/capture when taken (IDLE or DONE only).
//   In RUN, stop takes priority over start.
//
// Optional feature (macro ALU_CHK_STOP_ON_FAIL_EN):
//   The first mismatch seen in S2 forces DONE on that edge and discards the
//   vector being loaded into S1 at the same edge.
//
// Ports:
//   clk, rst_n          clock (rising), asynchronous active-low reset
//   start, stop         control pulses
//   in_valid/in_ready   vector handshake
//   a, b, aluc          operands and opcode as applied to the alu
//   dut_r, dut_flags    DUT result and {z,c,n,v}
//   pass_cnt, fail_cnt  saturating counters of matched / mismatched vectors
//   ff_idx, ff_aluc,
//   ff_exp_r, ff_mask   first failure: accept index, opcode, golden r,
//                       mismatch bits {r,z,c,n,v}
//   any_fail            sticky failure indication, cleared by start
//   done                high in DONE
// -----------------------------------------------------------------------------
module alu_result_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [3:0]       aluc,
  input  logic [31:0]      dut_r,
  input  logic [3:0]       dut_flags,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] ff_idx,
  output logic [3:0]       ff_aluc,
  output logic [31:0]      ff_exp_r,
  output logic [4:0]       ff_mask,
  output logic             any_fail,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e state_q, state_d;

  logic transfer;
  logic clear;
  logic s2_fail;
  logic halt_on_fail;

  // ---------------------------------------------------------------------------
  // Golden model (combinational on the live inputs)
  // ---------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic [32:0] sum33;
  logic [32:0] sll33;
  logic [32:0] srl33;
  logic [32:0] sra33;
  logic [31:0] diff;
  logic        borrow;
  logic [31:0] gold_r;
  logic        gold_c;
  logic        gold_v;
  logic        chk_c;
  logic        chk_v;
  logic [3:0]  gold_flags;
  logic [4:0]  gold_chk;

  always_comb begin
    shamt  = a[4:0];
    sum33  = {1'b0, a} + {1'b0, b};
    diff   = a - b;
    borrow = (a < b);
    // Shifts run on a 33-bit value so the last bit shifted out lands in a
    // fixed position: bit 32 for left shifts, bit 0 for right shifts.
    sll33  = {1'b0, b} << shamt;
    srl33  = {b, 1'b0} >> shamt;
    sra33  = $signed({b, 1'b0}) >>> shamt;

    gold_r = 32'd0;
    gold_c = 1'b0;
    gold_v = 1'b0;
    chk_c  = 1'b0;
    chk_v  = 1'b0;

    case (aluc)
      4'b0000: begin // addu
        gold_r = sum33[31:0];
        gold_c = sum33[32];
        chk_c  = 1'b1;
      end
      4'b0010: begin // add
        gold_r = sum33[31:0];
        gold_v = (a[31] == b[31]) && (gold_r[31] != a[31]);
        chk_v  = 1'b1;
      end
      4'b0001: begin // subu
        gold_r = diff;
        gold_c = borrow;
        chk_c  = 1'b1;
      end
      4'b0011: begin // sub
        gold_r = diff;
        gold_v = (a[31] != b[31]) && (gold_r[31] != a[31]);
        chk_v  = 1'b1;
      end
      4'b0100: gold_r = a & b;
      4'b0101: gold_r = a | b;
      4'b0110: gold_r = a ^ b;
      4'b0111: gold_r = ~(a | b);
      4'b1011: gold_r = {31'd0, ($signed(a) < $signed(b))};
      4'b1010: begin // sltu
        gold_r = {31'd0, borrow};
        gold_c = borrow;
        chk_c  = 1'b1;
      end
      4'b1110, 4'b1111: begin // sll
        gold_r = sll33[31:0];
        gold_c = sll33[32];
        chk_c  = (shamt != 5'd0);
      end
      4'b1101: begin // srl
        gold_r = srl33[32:1];
        gold_c = srl33[0];
        chk_c  = (shamt != 5'd0);
      end
      4'b1100: begin // sra
        gold_r = sra33[32:1];
        gold_c = sra33[0];
        chk_c  = (shamt != 5'd0);
      end
      default: begin // 1000, 1001: lui
        gold_r = {b[15:0], 16'h0000};
      end
    endcase

    gold_flags = {(gold_r == 32'd0), gold_c, gold_r[31], gold_v};
    // {r,z,c,n,v}: r, z and n are always compared.
    gold_chk   = {1'b1, 1'b1, chk_c, 1'b1, chk_v};
  end

  // ---------------------------------------------------------------------------
  // S1 and S2 registers
  // ---------------------------------------------------------------------------
  logic             s1_valid_q,     s1_valid_d;
  logic [CNT_W-1:0] s1_idx_q,       s1_idx_d;
  logic [3:0]       s1_aluc_q,      s1_aluc_d;
  logic [31:0]      s1_dut_r_q,     s1_dut_r_d;
  logic [3:0]       s1_dut_flags_q, s1_dut_flags_d;
  logic [31:0]      s1_exp_r_q,     s1_exp_r_d;
  logic [3:0]       s1_exp_flags_q, s1_exp_flags_d;
  logic [4:0]       s1_chk_q,       s1_chk_d;

  logic [CNT_W-1:0] idx_cnt_q,  idx_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] ff_idx_q,   ff_idx_d;
  logic [3:0]       ff_aluc_q,  ff_aluc_d;
  logic [31:0]      ff_exp_r_q, ff_exp_r_d;
  logic [4:0]       ff_mask_q,  ff_mask_d;
  logic             any_fail_q, any_fail_d;

  // S2 compare: unchecked fields are masked so they can never mismatch.
  logic [4:0] s2_mism;

  always_comb begin
    s2_mism = {(s1_dut_r_q != s1_exp_r_q),
               (s1_dut_flags_q[3] != s1_exp_flags_q[3]),
               (s1_dut_flags_q[2] != s1_exp_flags_q[2]),
               (s1_dut_flags_q[1] != s1_exp_flags_q[1]),
               (s1_dut_flags_q[0] != s1_exp_flags_q[0])} & s1_chk_q;
    s2_fail = s1_valid_q && (s2_mism != 5'd0);
  end

`ifdef ALU_CHK_STOP_ON_FAIL_EN
  assign halt_on_fail = s2_fail;
`else
  assign halt_on_fail = 1'b0;
`endif

  assign transfer = in_valid && in_ready;
  assign clear    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    // A halting failure drops whatever enters S1 on the same edge.
    s1_valid_d     = transfer && !halt_on_fail;
    s1_idx_d       = s1_idx_q;
    s1_aluc_d      = s1_aluc_q;
    s1_dut_r_d     = s1_dut_r_q;
    s1_dut_flags_d = s1_dut_flags_q;
    s1_exp_r_d     = s1_exp_r_q;
    s1_exp_flags_d = s1_exp_flags_q;
    s1_chk_d       = s1_chk_q;

    if (transfer) begin
      s1_idx_d       = idx_cnt_q;
      s1_aluc_d      = aluc;
      s1_dut_r_d     = dut_r;
      s1_dut_flags_d = dut_flags;
      s1_exp_r_d     = gold_r;
      s1_exp_flags_d = gold_flags;
      s1_chk_d       = gold_chk;
    end

    idx_cnt_d  = idx_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_idx_d   = ff_idx_q;
    ff_aluc_d  = ff_aluc_q;
    ff_exp_r_d = ff_exp_r_q;
    ff_mask_d  = ff_mask_q;
    any_fail_d = any_fail_q;

    if (clear) begin
      idx_cnt_d  = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      ff_idx_d   = '0;
      ff_aluc_d  = 4'd0;
      ff_exp_r_d = 32'd0;
      ff_mask_d  = 5'd0;
      any_fail_d = 1'b0;
    end else begin
      if (transfer && (idx_cnt_q != CNT_MAX)) begin
        idx_cnt_d = idx_cnt_q + CNT_ONE;
      end
      if (s1_valid_q) begin
        if (s2_fail) begin
          if (fail_cnt_q != CNT_MAX) begin
            fail_cnt_d = fail_cnt_q + CNT_ONE;
          end
          // Only the very first failure since start is captured.
          if (fail_cnt_q == '0) begin
            ff_idx_d   = s1_idx_q;
            ff_aluc_d  = s1_aluc_q;
            ff_exp_r_d = s1_exp_r_q;
            ff_mask_d  = s2_mism;
          end
          any_fail_d = 1'b1;
        end else if (pass_cnt_q != CNT_MAX) begin
          pass_cnt_d = pass_cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_idx_q       <= '0;
      s1_aluc_q      <= 4'd0;
      s1_dut_r_q     <= 32'd0;
      s1_dut_flags_q <= 4'd0;
      s1_exp_r_q     <= 32'd0;
      s1_exp_flags_q <= 4'd0;
      s1_chk_q       <= 5'd0;
      idx_cnt_q      <= '0;
      pass_cnt_q     <= '0;
      fail_cnt_q     <= '0;
      ff_idx_q       <= '0;
      ff_aluc_q      <= 4'd0;
      ff_exp_r_q     <= 32'd0;
      ff_mask_q      <= 5'd0;
      any_fail_q     <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_idx_q       <= s1_idx_d;
      s1_aluc_q      <= s1_aluc_d;
      s1_dut_r_q     <= s1_dut_r_d;
      s1_dut_flags_q <= s1_dut_flags_d;
      s1_exp_r_q     <= s1_exp_r_d;
      s1_exp_flags_q <= s1_exp_flags_d;
      s1_chk_q       <= s1_chk_d;
      idx_cnt_q      <= idx_cnt_d;
      pass_cnt_q     <= pass_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
      ff_idx_q       <= ff_idx_d;
      ff_aluc_q      <= ff_aluc_d;
      ff_exp_r_q     <= ff_exp_r_d;
      ff_mask_q      <= ff_mask_d;
      any_fail_q     <= any_fail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (stop) state_d = ST_DRAIN;
      // S2 has no payload of its own, so the pipeline is empty once S1 is.
      ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (halt_on_fail) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    in_ready = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign ff_idx   = ff_idx_q;
  assign ff_aluc  = ff_aluc_q;
  assign ff_exp_r = ff_exp_r_q;
  assign ff_mask  = ff_mask_q;
  assign any_fail = any_fail_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_result_checker
//
// Directed bench for alu_result_checker. A table of hand-computed vectors is
// pushed one at a time with counter checks after each; hand-written sequences
// cover drain timing, stop/start priority, back-to-back streams, counter
// saturation and asynchronous reset. CNT_W is reduced to 8 so saturation is
// reachable in a few hundred cycles. When ALU_CHK_STOP_ON_FAIL_EN is defined
// the stop-on-fail sequence runs instead of the sequences containing failures.
// -----------------------------------------------------------------------------
module tb_alu_result_checker;

  localparam int CNT_W = 8;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start     = 1'b0;
  logic             stop      = 1'b0;
  logic             in_valid  = 1'b0;
  logic [31:0]      a         = 32'd0;
  logic [31:0]      b         = 32'd0;
  logic [3:0]       aluc      = 4'd0;
  logic [31:0]      dut_r     = 32'd0;
  logic [3:0]       dut_flags = 4'd0;
  logic             in_ready;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] ff_idx;
  logic [3:0]       ff_aluc;
  logic [31:0]      ff_exp_r;
  logic [4:0]       ff_mask;
  logic             any_fail;
  logic             done;

  alu_result_checker #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .dut_r     (dut_r),
    .dut_flags (dut_flags),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .ff_idx    (ff_idx),
    .ff_aluc   (ff_aluc),
    .ff_exp_r  (ff_exp_r),
    .ff_mask   (ff_mask),
    .any_fail  (any_fail),
    .done      (done)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;      // value presented as DUT result
    logic [3:0]  flags;  // {z,c,n,v} presented as DUT flags
    logic        pass;   // expected verdict
    logic [4:0]  mask;   // expected mismatch bits {r,z,c,n,v}
    logic [31:0] exp_r;  // golden result
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vr, input logic [3:0] vf);
    in_valid  = 1'b1;
    aluc      = op;
    a         = va;
    b         = vb;
    dut_r     = vr;
    dut_flags = vf;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_pass"},     32'(pass_cnt), 32'd0);
    chk({tag, "_fail"},     32'(fail_cnt), 32'd0);
    chk({tag, "_ff_idx"},   32'(ff_idx),   32'd0);
    chk({tag, "_ff_aluc"},  32'(ff_aluc),  32'd0);
    chk({tag, "_ff_exp_r"}, ff_exp_r,      32'd0);
    chk({tag, "_ff_mask"},  32'(ff_mask),  32'd0);
    chk({tag, "_any_fail"}, 32'(any_fail), 32'd0);
  endtask

  logic [31:0] va, vb, vr;
  logic [3:0]  vf;
  logic        bad;
  int          exp_pass, exp_fail, first_bad;

  initial begin
    vecs[0]  = '{4'b0000, 32'h4321fedc, 32'h9321fedc, 32'hD643FDB8, 4'b0010, 1'b1, 5'b00000, 32'hD643FDB8};
    vecs[1]  = '{4'b0011, 32'h4321fedc, 32'h9321fedc, 32'hB0000000, 4'b0010, 1'b0, 5'b00001, 32'hB0000000};
    vecs[2]  = '{4'b1011, 32'hf0000000, 32'h00000000, 32'h00000001, 4'b0000, 1'b1, 5'b00000, 32'h00000001};
    vecs[3]  = '{4'b1010, 32'hf0000000, 32'h00000000, 32'h00000000, 4'b1000, 1'b1, 5'b00000, 32'h00000000};
    vecs[4]  = '{4'b1100, 32'h00000002, 32'hB77BEFDF, 32'hEDDEFBF7, 4'b0110, 1'b1, 5'b00000, 32'hEDDEFBF7};
    vecs[5]  = '{4'b1000, 32'h00000000, 32'hB77BEFDF, 32'hEFDF0000, 4'b0010, 1'b1, 5'b00000, 32'hEFDF0000};
    vecs[6]  = '{4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0110, 1'b1, 5'b00000, 32'hFFFFFFFE};
    vecs[7]  = '{4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 4'b0111, 1'b1, 5'b00000, 32'h80000000};
    vecs[8]  = '{4'b1110, 32'h00000004, 32'hF0000001, 32'h00000010, 4'b0100, 1'b1, 5'b00000, 32'h00000010};
    vecs[9]  = '{4'b1101, 32'h00000000, 32'h80000000, 32'h80000000, 4'b0110, 1'b1, 5'b00000, 32'h80000000};
    vecs[10] = '{4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b1000, 1'b1, 5'b00000, 32'h00000000};
    vecs[11] = '{4'b0101, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b1010, 1'b0, 5'b01000, 32'hFFFFFFFF};
    vecs[12] = '{4'b0110, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000, 1'b1, 5'b00000, 32'h00FFFF00};
    vecs[13] = '{4'b0111, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 4'b0010, 1'b0, 5'b10000, 32'hFFFFFFFF};
    vecs[14] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1'b1, 5'b00000, 32'h00000000};
    vecs[15] = '{4'b0001, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0010, 1'b0, 5'b00100, 32'hFFFFFFFF};
    vecs[16] = '{4'b1100, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 4'b0010, 1'b1, 5'b00000, 32'hFFFFFFFF};
    vecs[17] = '{4'b0011, 32'h00000005, 32'h00000003, 32'h00000002, 4'b0000, 1'b1, 5'b00000, 32'h00000002};

    // reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    pulse_start();
    chk("run_in_ready", 32'(in_ready), 32'd1);

`ifndef ALU_CHK_STOP_ON_FAIL_EN
    // table of single vectors
    exp_pass  = 0;
    exp_fail  = 0;
    first_bad = -1;
    for (int i = 0; i < NVEC; i++) begin
      drive_vec(vecs[i].aluc, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].flags);
      tick();
      in_valid = 1'b0;
      if (i == 0) chk("latency_pass_not_yet", 32'(pass_cnt), 32'd0);
      tick();
      if (vecs[i].pass) exp_pass++;
      else begin
        exp_fail++;
        if (first_bad < 0) first_bad = i;
      end
      chk($sformatf("tbl%0d_pass", i), 32'(pass_cnt), 32'(exp_pass));
      chk($sformatf("tbl%0d_fail", i), 32'(fail_cnt), 32'(exp_fail));
    end
    chk("tbl_ff_idx",   32'(ff_idx),   32'(first_bad));
    chk("tbl_ff_mask",  32'(ff_mask),  32'(vecs[first_bad].mask));
    chk("tbl_ff_exp_r", ff_exp_r,      vecs[first_bad].exp_r);
    chk("tbl_ff_aluc",  32'(ff_aluc),  32'(vecs[first_bad].aluc));
    chk("tbl_any_fail", 32'(any_fail), 32'd1);

    // vector on the stop cycle, with start asserted too: stop wins, vector counted
    drive_vec(4'b0000, 32'd1, 32'd1, 32'd2, 4'b0000);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    in_valid = 1'b0;
    stop     = 1'b0;
    start    = 1'b0;
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_done_e1",  32'(done),     32'd0);
    tick();
    chk("drain_done_e2",  32'(done),     32'd0);
    chk("drain_pass",     32'(pass_cnt), 32'(exp_pass + 1));
    tick();
    chk("done_set",       32'(done),     32'd1);
    chk("done_fail_kept", 32'(fail_cnt), 32'(exp_fail));

    // valid while DONE is not accepted
    drive_vec(4'b0000, 32'd1, 32'd1, 32'd2, 4'b0000);
    repeat (3) tick();
    in_valid = 1'b0;
    chk("done_no_accept", 32'(pass_cnt), 32'(exp_pass + 1));

    // restart clears; 100 back-to-back vectors with 5 wrong results
    pulse_start();
    chk("restart_pass",     32'(pass_cnt), 32'd0);
    chk("restart_fail",     32'(fail_cnt), 32'd0);
    chk("restart_any_fail", 32'(any_fail), 32'd0);
    chk("restart_ff_mask",  32'(ff_mask),  32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 100; i++) begin
      va  = $urandom;
      vb  = $urandom;
      vr  = va & vb;
      vf  = {(vr == 32'd0), 1'b0, vr[31], 1'b0};
      bad = (i == 7) || (i == 20) || (i == 21) || (i == 63) || (i == 98);
      if (bad) begin
        exp_q.push_back(vr);
        vr = vr ^ 32'h0000_0100;
      end
      drive_vec(4'b0100, va, vb, vr, vf);
      stop = (i == 99);
      tick();
    end
    in_valid = 1'b0;
    stop     = 1'b0;
    chk("b2b_done_e1", 32'(done), 32'd0);
    tick();
    chk("b2b_done_e2", 32'(done), 32'd0);
    tick();
    chk("b2b_done",     32'(done),     32'd1);
    chk("b2b_pass",     32'(pass_cnt), 32'd95);
    chk("b2b_fail",     32'(fail_cnt), 32'd5);
    chk("b2b_ff_idx",   32'(ff_idx),   32'd7);
    chk("b2b_ff_mask",  32'(ff_mask),  32'b10000);
    chk("b2b_ff_exp_r", ff_exp_r,      exp_q[0]);
    chk("b2b_ff_aluc",  32'(ff_aluc),  32'd4);

    // saturation: 299 passing vectors then one failure at index 299
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      va = $urandom;
      vb = $urandom;
      vr = va ^ vb;
      vf = {(vr == 32'd0), 1'b0, vr[31], 1'b0};
      if (i == 299) vr = ~vr;
      drive_vec(4'b0110, va, vb, vr, vf);
      stop = (i == 299);
      tick();
    end
    in_valid = 1'b0;
    stop     = 1'b0;
    repeat (2) tick();
    chk("sat_done",   32'(done),     32'd1);
    chk("sat_pass",   32'(pass_cnt), 32'd255);
    chk("sat_fail",   32'(fail_cnt), 32'd1);
    chk("sat_ff_idx", 32'(ff_idx),   32'd255);
`else
    // stop on first failure: index 3 bad in a continuous stream
    for (int i = 0; i < 8; i++) begin
      vr = (i == 3) ? 32'hDEAD0000 : 32'(i + i);
      drive_vec(4'b0000, 32'(i), 32'(i), vr, {(i == 0), 1'b0, 1'b0, 1'b0});
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sof_done",     32'(done),     32'd1);
    chk("sof_in_ready", 32'(in_ready), 32'd0);
    chk("sof_pass",     32'(pass_cnt), 32'd3);
    chk("sof_fail",     32'(fail_cnt), 32'd1);
    chk("sof_ff_idx",   32'(ff_idx),   32'd3);
    chk("sof_ff_mask",  32'(ff_mask),  32'b10000);
    chk("sof_ff_exp_r", ff_exp_r,      32'd6);
`endif

    // asynchronous reset with two vectors in flight
    pulse_start();
    drive_vec(4'b0000, 32'd3, 32'd4, 32'd7, 4'b0000);
    tick();
    drive_vec(4'b0000, 32'd5, 32'd6, 32'd11, 4'b0000);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    chk_all_zero("post_rst_idle");
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
